// File: rtl/fp_window_pkg.sv
// Shared definitions for the FP16 horizontal window generator.
// Holds the half-precision width constants, the pixel type, the +0.0 constant
// and the two-state controller enum used by window_generator_h_fp16.
package fp_window_pkg;

    localparam int EXP_WIDTH    = 5;
    localparam int FRAC_WIDTH   = 10;
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;

    typedef logic [FP_WIDTH_REG-1:0] fp_t;

    localparam fp_t FP_ZERO = {FP_WIDTH_REG{1'b0}};

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } window_state_e;

endpackage

// File: rtl/window_generator_h_fp16_if.sv
// Pixel-in / window-out bundle of the horizontal window generator.
//   data_i/col_i/row_i/valid_i : raster pixel stream (no backpressure)
//   window_o/col_o/row_o/valid_o : centre-aligned 1xWINDOW_WIDTH window + centre coordinates
// master: pixel producer / window consumer side; slave: the generator itself.
interface window_generator_h_fp16_if #(
    parameter int WINDOW_WIDTH = 5
);
    import fp_window_pkg::*;

    fp_t         data_i;
    logic [15:0] col_i;
    logic [15:0] row_i;
    logic        valid_i;

    logic [0:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
    logic [15:0] col_o;
    logic [15:0] row_o;
    logic        valid_o;

    modport master (
        output data_i, col_i, row_i, valid_i,
        input  window_o, col_o, row_o, valid_o
    );

    modport slave (
        input  data_i, col_i, row_i, valid_i,
        output window_o, col_o, row_o, valid_o
    );

endinterface

// File: rtl/window_edge_select.sv
// Per-tap window multiplexer. For window position TAP around centre_i it
// returns the shift-register tap (src_i[TAP+shift_i]) when the position lies
// inside the row, otherwise the left/right edge pixel (replication) or +0.0
// when WINDOW_GEN_ZERO_PAD_EN is defined.
// Ports: src_i taps, shift_i tap offset, centre_i centre column,
//        edge_lo_i col-0 pixel, edge_hi_i last-col pixel, pix_o selected pixel.
module window_edge_select
    import fp_window_pkg::*;
#(
    parameter int WINDOW_WIDTH = 5,
    parameter int IMAGE_WIDTH  = 640,
    parameter int TAP          = 0
) (
    input  logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] src_i,
    input  logic [15:0]                               shift_i,
    input  logic [15:0]                               centre_i,
    input  fp_t                                       edge_lo_i,
    input  fp_t                                       edge_hi_i,
    output fp_t                                       pix_o
);

    localparam int RADIUS = (WINDOW_WIDTH - 1) / 2;

    logic signed [17:0] pos_s;
    logic [16:0]        idx_s;
    logic               is_lo_s;
    logic               is_hi_s;
    fp_t                tap_s;
    fp_t                lo_s;
    fp_t                hi_s;

    // Column this tap refers to; negative values fall off the left edge.
    assign pos_s   = $signed({2'b00, centre_i}) + $signed(18'(TAP)) - $signed(18'(RADIUS));
    assign is_lo_s = pos_s[17];
    assign is_hi_s = !pos_s[17] && (pos_s[16:0] > 17'(IMAGE_WIDTH - 1));
    assign idx_s   = 17'(TAP) + {1'b0, shift_i};

`ifdef WINDOW_GEN_ZERO_PAD_EN
    assign lo_s = FP_ZERO;
    assign hi_s = FP_ZERO;
`else
    assign lo_s = edge_lo_i;
    assign hi_s = edge_hi_i;
`endif

    // Pick the shifted tap; indices past the end only occur for out-of-row positions.
    always_comb begin
        tap_s = src_i[WINDOW_WIDTH-1];
        for (int i = 0; i < WINDOW_WIDTH; i++) begin
            if (idx_s == 17'(i)) begin
                tap_s = src_i[i];
            end else begin
                tap_s = tap_s;
            end
        end
    end

    // Final choice between in-row tap and edge value.
    always_comb begin
        if (is_lo_s) begin
            pix_o = lo_s;
        end else if (is_hi_s) begin
            pix_o = hi_s;
        end else begin
            pix_o = tap_s;
        end
    end

endmodule

// File: rtl/window_generator_h_fp16.sv
// Horizontal sliding-window generator (FP16 pixels, bit-exact pass-through).
// Accepting column c+RADIUS emits the window centred on c one cycle later; the
// RADIUS tail windows of a row are flushed on the cycles after the last pixel,
// overlapping the next row's first RADIUS pixels, which produce no output.
// Ports: clk_i clock, rst_i synchronous active-high reset,
//        bus (slave modport of window_generator_h_fp16_if) pixel in / window out.
// Optional build macro: WINDOW_GEN_ZERO_PAD_EN (out-of-row taps = +0.0).
module window_generator_h_fp16
    import fp_window_pkg::*;
#(
    parameter int WINDOW_WIDTH = 5,
    parameter int IMAGE_WIDTH  = 640
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    window_generator_h_fp16_if.slave bus
);

    localparam int W      = WINDOW_WIDTH;
    localparam int RADIUS = (WINDOW_WIDTH - 1) / 2;

    typedef logic [W-1:0][FP_WIDTH_REG-1:0] taps_t;

    window_state_e state_q, state_d;
    taps_t         sr_q, sr_d, tail_q, tail_d, win_q, win_d;
    fp_t           left_q, left_d;
    logic          active_q, active_d;
    logic [15:0]   flush_k_q, flush_k_d, tail_row_q, tail_row_d;
    logic [15:0]   col_q, col_d, row_q, row_d;
    logic          valid_q, valid_d;

    logic          row_start_s, main_emit_s, last_s, flush_emit_s;
    taps_t         src_s, sel_s;
    fp_t           hi_s;
    logic [15:0]   shift_s, centre_s;

    assign row_start_s  = bus.valid_i && (bus.col_i == 16'd0);
    assign flush_emit_s = (state_q == FLUSH);
    // Windows only start after a row start has been seen since reset.
    assign main_emit_s  = bus.valid_i && (active_q || row_start_s) && (bus.col_i >= 16'(RADIUS));
    assign last_s       = bus.valid_i && (active_q || row_start_s) && (bus.col_i == 16'(IMAGE_WIDTH - 1));

    // Shift register: a row start fills every tap with the col-0 pixel.
    always_comb begin
        sr_d     = sr_q;
        left_d   = left_q;
        active_d = active_q;
        if (row_start_s) begin
            for (int j = 0; j < W; j++) begin
                sr_d[j] = bus.data_i;
            end
            left_d   = bus.data_i;
            active_d = 1'b1;
        end else if (bus.valid_i) begin
            for (int j = 0; j < W - 1; j++) begin
                sr_d[j] = sr_q[j+1];
            end
            sr_d[W-1] = bus.data_i;
        end else begin
            sr_d = sr_q;
        end
    end

    // Window source: tail buffer while flushing, live shift register otherwise.
    always_comb begin
        if (flush_emit_s) begin
            src_s    = tail_q;
            hi_s     = tail_q[W-1];
            shift_s  = 16'd1 + flush_k_q;
            centre_s = 16'(IMAGE_WIDTH - RADIUS) + flush_k_q;
        end else begin
            src_s    = sr_d;
            hi_s     = sr_d[W-1];
            shift_s  = 16'd0;
            centre_s = bus.col_i - 16'(RADIUS);
        end
    end

    for (genvar j = 0; j < W; j++) begin : g_tap
        window_edge_select #(
            .WINDOW_WIDTH (WINDOW_WIDTH),
            .IMAGE_WIDTH  (IMAGE_WIDTH),
            .TAP          (j)
        ) u_sel (
            .src_i     (src_s),
            .shift_i   (shift_s),
            .centre_i  (centre_s),
            .edge_lo_i (left_d),
            .edge_hi_i (hi_s),
            .pix_o     (sel_s[j])
        );
    end

    // RUN/FLUSH control and next output values.
    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        tail_row_d = tail_row_q;
        flush_k_d  = flush_k_q;
        case (state_q)
            RUN: begin
                flush_k_d = 16'd0;
            end
            FLUSH: begin
                if (flush_k_q == 16'(RADIUS - 1)) begin
                    state_d   = RUN;
                    flush_k_d = 16'd0;
                end else begin
                    flush_k_d = flush_k_q + 16'd1;
                end
            end
            default: begin
                state_d   = RUN;
                flush_k_d = 16'd0;
            end
        endcase
        // End of row (re)arms the flush; a malformed stream cannot wedge it.
        if (last_s) begin
            state_d    = FLUSH;
            tail_d     = sr_d;
            tail_row_d = bus.row_i;
            flush_k_d  = 16'd0;
        end else begin
            tail_d = tail_d;
        end

        valid_d = 1'b0;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        if (flush_emit_s) begin
            valid_d = 1'b1;
            col_d   = centre_s;
            row_d   = tail_row_q;
            win_d   = sel_s;
        end else if (main_emit_s) begin
            valid_d = 1'b1;
            col_d   = centre_s;
            row_d   = bus.row_i;
            win_d   = sel_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            sr_q       <= '0;
            tail_q     <= '0;
            left_q     <= FP_ZERO;
            active_q   <= 1'b0;
            flush_k_q  <= 16'd0;
            tail_row_q <= 16'd0;
            win_q      <= '0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            tail_q     <= tail_d;
            left_q     <= left_d;
            active_q   <= active_d;
            flush_k_q  <= flush_k_d;
            tail_row_q <= tail_row_d;
            win_q      <= win_d;
            col_q      <= col_d;
            row_q      <= row_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.window_o[0] = win_q;
    assign bus.col_o       = col_q;
    assign bus.row_o       = row_q;
    assign bus.valid_o     = valid_q;

endmodule

// File: tb/tb_window_generator_h_fp16.sv
// Scoreboard bench for window_generator_h_fp16 (IMAGE_WIDTH=8, WINDOW_WIDTH=5).
// Honours WINDOW_GEN_ZERO_PAD_EN in its reference model.
module tb_window_generator_h_fp16;

    localparam int W  = 5;
    localparam int IW = 8;
    localparam int R  = (W - 1) / 2;

    typedef logic [0:0][W-1:0][15:0] win_t;
    typedef struct {
        logic [15:0] col;
        logic [15:0] row;
        win_t        win;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    exp_t mon_it;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    bit   cap_en = 1'b0;
    win_t cap [IW];
    logic [15:0] row_pix [IW];
    bit   active = 1'b0;

    window_generator_h_fp16_if #(.WINDOW_WIDTH(W)) bus ();

    window_generator_h_fp16 #(
        .WINDOW_WIDTH (W),
        .IMAGE_WIDTH  (IW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference window: centre c, positions outside the row replicated or zeroed.
    function automatic win_t model_win(input int c);
        win_t w;
        for (int j = 0; j < W; j++) begin
            int pos = c - R + j;
`ifdef WINDOW_GEN_ZERO_PAD_EN
            if (pos < 0 || pos > IW - 1) w[0][j] = 16'h0000;
            else                         w[0][j] = row_pix[pos];
`else
            if (pos < 0)           w[0][j] = row_pix[0];
            else if (pos > IW - 1) w[0][j] = row_pix[IW-1];
            else                   w[0][j] = row_pix[pos];
`endif
        end
        return w;
    endfunction

    task automatic model_accept(input logic [15:0] d, input int c, input int r, input int e);
        exp_t it;
        if (c == 0) active = 1'b1;
        if (!active) return;
        row_pix[c] = d;
        if (c >= R) begin
            it.col = 16'(c - R); it.row = 16'(r); it.win = model_win(c - R); it.cyc = e;
            q.push_back(it);
        end
        if (c == IW - 1) begin
            for (int k = 0; k < R; k++) begin
                it.col = 16'(IW - R + k); it.row = 16'(r); it.win = model_win(IW - R + k); it.cyc = e + 1 + k;
                q.push_back(it);
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input int c, input int r);
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.data_i = d; bus.col_i = 16'(c); bus.row_i = 16'(r);
        model_accept(d, c, r, cyc + 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d windows pending expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.valid_i = 1'b0;
        @(negedge clk); #1;
        q.delete();
        active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 80'(bus.valid_o), 80'(1'b0));
        chk("rst_window", bus.window_o, 80'd0);
        chk("rst_col", 80'(bus.col_o), 80'd0);
        chk("rst_row", 80'(bus.row_o), 80'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a window.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            n_out++;
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_window: got col %0d row %0d expected no window", bus.col_o, bus.row_o);
            end else begin
                mon_it = q.pop_front();
                chk("win_cycle", 80'(cyc), 80'(mon_it.cyc));
                chk("win_col", 80'(bus.col_o), 80'(mon_it.col));
                chk("win_row", 80'(bus.row_o), 80'(mon_it.row));
                chk("win_data", bus.window_o, mon_it.win);
                if (cap_en) cap[bus.col_o[2:0]] = bus.window_o;
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_it = q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missed_window: got no window expected col %0d at cycle %0d", mon_it.col, mon_it.cyc);
        end
    end

    initial begin
        logic [15:0] row0 [IW];
        win_t e0, e7;
        int   out0;
        row0[0] = 16'h3C00; row0[1] = 16'h4000; row0[2] = 16'h4200; row0[3] = 16'h4400;
        row0[4] = 16'h4500; row0[5] = 16'h4600; row0[6] = 16'h4700; row0[7] = 16'h4800;

        rst = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = 16'h0000; bus.col_i = 16'd0; bus.row_i = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 80'(bus.valid_o), 80'(1'b0));
        chk("reset_col", 80'(bus.col_o), 80'd0);
        chk("reset_row", 80'(bus.row_o), 80'd0);
        chk("reset_window", bus.window_o, 80'd0);

        // No input: outputs stay at reset values.
        repeat (6) begin
            @(negedge clk);
            chk("idle_valid", 80'(bus.valid_o), 80'(1'b0));
            chk("idle_window", bus.window_o, 80'd0);
        end

        // Directed row with known windows at both edges.
        out0 = n_out;
        cap_en = 1'b1;
        for (int c = 0; c < IW; c++) send(row0[c], c, 0);
        idle();
        drain();
        cap_en = 1'b0;
`ifdef WINDOW_GEN_ZERO_PAD_EN
        e0[0][0] = 16'h0000; e0[0][1] = 16'h0000;
        e7[0][3] = 16'h0000; e7[0][4] = 16'h0000;
`else
        e0[0][0] = 16'h3C00; e0[0][1] = 16'h3C00;
        e7[0][3] = 16'h4800; e7[0][4] = 16'h4800;
`endif
        e0[0][2] = 16'h3C00; e0[0][3] = 16'h4000; e0[0][4] = 16'h4200;
        e7[0][0] = 16'h4600; e7[0][1] = 16'h4700; e7[0][2] = 16'h4800;
        chk("row0_col0_window", cap[0], e0);
        chk("row0_col7_window", cap[7], e7);
        chk("row0_window_count", 80'(n_out - out0), 80'd8);

        // Two rows back to back: tails overlap the next row's first pixels.
        for (int r = 1; r <= 2; r++)
            for (int c = 0; c < IW; c++) send(16'($urandom), c, r);
        idle();
        drain();

        // Three rows with random gaps.
        for (int r = 3; r <= 5; r++)
            for (int c = 0; c < IW; c++) begin
                while ($urandom_range(0, 1) == 1) idle();
                send(16'($urandom), c, r);
            end
        idle();
        drain();

        // Reset during flush, after tail col 6 but before tail col 7.
        for (int c = 0; c < IW; c++) send(16'($urandom), c, 6);
        idle();
        do_reset();
        // Pixels without a row start produce nothing.
        send(16'h1234, 3, 7);
        send(16'h5678, 4, 7);
        idle();
        repeat (4) begin
            @(negedge clk);
            chk("norowstart_valid", 80'(bus.valid_o), 80'(1'b0));
        end
        for (int c = 0; c < IW; c++) send(16'($urandom), c, 8);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_generator_h_fp16.md
Name: window_generator_h_fp16

Overview:
Horizontal sliding-window generator that turns a raster pixel stream into centre-aligned 1xWINDOW_WIDTH windows, tagged with coordinates. It is the producer for the horizontal convolution stage: its window/col/row/valid outputs drive that stage's window_i/col_i/row_i/valid_i directly. Row borders are handled by edge replication, so the downstream convolution always sees a full window. The tail windows of each row are flushed during the next row's first RADIUS input cycles, which never produce output.

Parameters:
EXP_WIDTH, 5, FP exponent width
FRAC_WIDTH, 10, FP fraction width
WINDOW_WIDTH, 5, window width; must be odd, >=3
IMAGE_WIDTH, 640, pixels per row; must be >= WINDOW_WIDTH
FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, pixel width (derived)
RADIUS, (WINDOW_WIDTH-1)/2, window half-width (derived)

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous reset, active-high
data_i  in  FP_WIDTH_REG  input pixel
col_i  in  16  input pixel column
row_i  in  16  input pixel row
valid_i  in  1  input pixel valid; no backpressure
window_o  out  FP_WIDTH_REG x [1][WINDOW_WIDTH]  window; [0][j] = pixel at col_o-RADIUS+j
col_o  out  16  centre column
row_o  out  16  centre row
valid_o  out  1  window valid

Behaviour:
- Single clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: valid_o=0, col_o=0, row_o=0, all window_o elements=0. Flush state cleared, shift register zeroed.
- An input is accepted on every cycle with valid_i=1. The stream is strictly raster: col_i counts 0..IMAGE_WIDTH-1 per row, and gaps (valid_i=0) are allowed anywhere.
- col_i==0 starts a new row and loads the shift register fresh. Non-sequential col_i other than a restart at 0 is unsupported; the resulting output is undefined, but the block must not lock up.
- Main path: accepting the pixel at column c+RADIUS emits the window centred at c on the next cycle.
  - This applies for c in 0..IMAGE_WIDTH-1-RADIUS.
  - valid_o=1, col_o=c, row_o=row of that pixel.
- Edges: window positions with index <0 take pixel col 0; positions with index >IMAGE_WIDTH-1 take pixel col IMAGE_WIDTH-1 (replicate).
- FSM has two states, RUN and FLUSH.
- RUN -> FLUSH: on accepting col_i==IMAGE_WIDTH-1.
  - The shift register is copied into a tail buffer.
  - The row is latched.
  - The flush counter is set to 0.
- FLUSH emits one tail window per cycle, unconditionally and independent of valid_i.
  - Cycle k emits centre col IMAGE_WIDTH-RADIUS+k, for k=0..RADIUS-1.
  - FLUSH -> RUN after k=RADIUS-1.
- Timing: last pixel accepted at cycle t.
  - Main window col IMAGE_WIDTH-1-RADIUS appears at t+1.
  - Tail windows appear at t+2 .. t+RADIUS+1.
- Simultaneous events: new-row pixels (col 0..RADIUS-1) may be accepted during FLUSH. They shift into the main register and produce no output. Col RADIUS can arrive at t+RADIUS+1 at the earliest, so its output (t+RADIUS+2) never collides with a tail window.
- Reset mid-row or mid-flush: abort immediately, with valid_o=0 on the next cycle. The next window appears only after a fresh col_i==0 row start.
- Data is passed through bit-exact; no arithmetic is performed on pixel values.
- Output is registered, with 1-cycle latency from the enabling event.

Optional Feature:
WINDOW_GEN_ZERO_PAD_EN
- Defined: out-of-row window positions are driven with +0.0 (all zeros) instead of the replicated edge pixel.
- Undefined: edge replication as described above.
- Timing, valid and coordinates are identical in both builds.

Decomposition:
- Package fp_window_pkg holds:
  - the FP16 width constants (EXP_WIDTH, FRAC_WIDTH, FP_WIDTH_REG);
  - the fp_t typedef;
  - the FP_ZERO constant;
  - the window_state_e enum {RUN, FLUSH}.
- One sub-module, window_edge_select: combinational per-tap mux that chooses the shift-register tap, the edge pixel, or zero from the centre col, RADIUS and IMAGE_WIDTH. It is instantiated WINDOW_WIDTH times.

Test Plan:
1. IMAGE_WIDTH=8, WINDOW_WIDTH=5; one row of 3C00,4000,4200,4400,4500,4600,4700,4800 back-to-back:
   - first output (col 0) is [3C00,3C00,3C00,4000,4200];
   - col 7 is [4600,4700,4800,4800,4800];
   - 8 valid outputs, col_o 0..7 in order.
2. Same row, WINDOW_GEN_ZERO_PAD_EN defined -> col 0 is [0000,0000,3C00,4000,4200]; col 7 is [4600,4700,4800,0000,0000].
3. Two rows back-to-back with no gap:
   - row-0 tail cols 6,7 emitted on the two cycles after col-5;
   - row-1 col 0 emitted one cycle after row-1 col-2 is accepted, with row_o=1;
   - no dropped or duplicated windows.
4. Random valid_i gaps (50%) over 3 rows -> output sequence identical to test 1/3 ordering; tail windows not delayed by gaps.
5. rst_i asserted during FLUSH (after tail col 6) -> valid_o=0 the next cycle and col 7 is never emitted; a new row after reset produces correct windows.
6. valid_i=0 throughout -> valid_o stays 0 and window_o holds its reset value.
